count_wrap_monitor: RTL
=======================

COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of each wrap-event counter.
REQ-002 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port count  input  4  count value from the upstream 4-bit up/down counter, same clk domain.
REQ-005 Port clr  input  1  synchronous clear of the event counters and error state.
REQ-006 Port ovf_pulse  output  1  one-cycle pulse on an observed 15->0 up-wrap.
REQ-007 Port unf_pulse  output  1  one-cycle pulse on an observed 0->15 down-wrap.
REQ-008 Port ovf_cnt  output  CNT_W  saturating count of up-wraps.
REQ-009 Port unf_cnt  output  CNT_W  saturating count of down-wraps.
REQ-010 Port dir  output  1  last observed step direction: 1 = up, 0 = down.
REQ-011 Port step_err  output  1  sticky flag for an illegal step (see Configuration).

Function
REQ-012 The block SHALL hold a 4-bit register prev with the count sampled at the previous edge, and a 3-state FSM: PRIME, TRACK, ERR.
REQ-013 In PRIME the block SHALL load prev <= count, emit no pulses, leave the counters unchanged, and go to TRACK at the next edge.
REQ-014 In TRACK, each edge SHALL compute delta = (count - prev) mod 16 and load prev <= count.
REQ-015 delta = 1: dir <= 1; if prev = 15, assert ovf_pulse for the next cycle and increment ovf_cnt.
REQ-016 delta = 15: dir <= 0; if prev = 0, assert unf_pulse for the next cycle and increment unf_cnt.
REQ-017 delta = 0: hold. No pulse, dir unchanged, counters unchanged.
REQ-018 Any other delta is an illegal step, handled per REQ-027/REQ-028.
REQ-019 Latency: when the upstream counter wraps at edge N, the pulse SHALL be high from edge N+1 to edge N+2 (exactly one cycle). The counter updates at edge N+1.
REQ-020 ovf_cnt and unf_cnt SHALL saturate at 2^CNT_W-1. At saturation the pulses still fire.
REQ-021 ovf_pulse and unf_pulse SHALL never be high in the same cycle.
REQ-022 clr = 1 at an edge SHALL:
- zero both counters;
- clear step_err;
- deassert both pulses;
- move the FSM to PRIME.
clr overrides any simultaneous wrap or error detection; dir is unchanged.
REQ-023 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-024 While rst = 1 the block SHALL asynchronously force:
- FSM = PRIME, prev = 0;
- ovf_pulse = 0, unf_pulse = 0;
- ovf_cnt = 0, unf_cnt = 0;
- dir = 1, step_err = 0.
REQ-025 Reset asserted mid-pulse or mid-operation SHALL clear the pulse immediately. No wrap is counted for the edge on which rst deasserts.
REQ-026 After rst deasserts, the first edge SHALL be a PRIME cycle, so no false wrap is seen against the reset value of prev.

Configuration
REQ-027 With macro STEP_CHECK_EN defined:
- an illegal step in TRACK sets step_err = 1 and moves the FSM to ERR;
- in ERR, prev keeps tracking but no pulses or counts occur;
- ERR exits only via clr (to PRIME) or rst.
REQ-028 With STEP_CHECK_EN undefined:
- step_err is tied to 0 and the ERR state is not implemented;
- an illegal step only updates prev, with no pulse, count or dir change, and the FSM stays in TRACK.

Verification
REQ-029 Reset, then drive count 0,1,...,15,0 one per cycle -> exactly one ovf_pulse, one cycle after count=0 appears; ovf_cnt = 1, unf_cnt = 0, dir = 1.
REQ-030 Drive count 2,1,0,15,14 -> exactly one unf_pulse; unf_cnt = 1, dir = 0, ovf_pulse never high.
REQ-031 Hold count = 7 for 10 cycles, then step to 8 -> no pulses, counters unchanged, dir = 1.
REQ-032 CNT_W = 2: force 5 up-wraps -> ovf_cnt stops at 3 and all 5 pulses are seen. Assert clr in the same cycle as a wrap -> ovf_cnt = 0 and no pulse.
REQ-033 STEP_CHECK_EN defined: step 4 -> 9 -> step_err = 1 next cycle. A following 15->0 wrap -> no pulse. After clr -> step_err = 0, and the next 15->0 wrap counts. With STEP_CHECK_EN undefined, the same stimulus -> step_err stays 0.
REQ-034 Assert rst for 3 ns while ovf_pulse = 1 -> all outputs return to reset values immediately. The first cycle after release produces no pulse even if count = 0 and prev was 15.

Source files
------------

// File: rtl/count_wrap_monitor.sv
// Watches a 4-bit up/down counter and reports 15->0 and 0->15 wraps as pulses and saturating counts.
// Optional macro STEP_CHECK_EN adds an ERR state and sticky step_err for steps other than -1/0/+1.
module count_wrap_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       count,
    input  logic             clr,
    output logic             ovf_pulse,
    output logic             unf_pulse,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] unf_cnt,
    output logic             dir,
    output logic             step_err
);

`ifdef STEP_CHECK_EN
    typedef enum logic [1:0] {PRIME, TRACK, ERR} state_t;
`else
    typedef enum logic [1:0] {PRIME, TRACK} state_t;
`endif

    state_t     state;
    logic [3:0] prev;
    logic [3:0] delta;

    // Modulo-16 difference: 1 is an up step, 15 a down step.
    assign delta = count - prev;

`ifndef STEP_CHECK_EN
    assign step_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PRIME;
            prev      <= 4'd0;
            ovf_pulse <= 1'b0;
            unf_pulse <= 1'b0;
            ovf_cnt   <= '0;
            unf_cnt   <= '0;
            dir       <= 1'b1;
`ifdef STEP_CHECK_EN
            step_err  <= 1'b0;
`endif
        end else begin
            ovf_pulse <= 1'b0;
            unf_pulse <= 1'b0;
            prev      <= count;
            if (clr) begin
                ovf_cnt  <= '0;
                unf_cnt  <= '0;
                state    <= PRIME;
`ifdef STEP_CHECK_EN
                step_err <= 1'b0;
`endif
            end else begin
                case (state)
                    PRIME: state <= TRACK;
                    TRACK: begin
                        if (delta == 4'd1) begin
                            dir <= 1'b1;
                            if (prev == 4'd15) begin
                                ovf_pulse <= 1'b1;
                                if (ovf_cnt != {CNT_W{1'b1}})
                                    ovf_cnt <= ovf_cnt + CNT_W'(1);
                            end
                        end else if (delta == 4'd15) begin
                            dir <= 1'b0;
                            if (prev == 4'd0) begin
                                unf_pulse <= 1'b1;
                                if (unf_cnt != {CNT_W{1'b1}})
                                    unf_cnt <= unf_cnt + CNT_W'(1);
                            end
                        end
`ifdef STEP_CHECK_EN
                        else if (delta != 4'd0) begin
                            step_err <= 1'b1;
                            state    <= ERR;
                        end
`endif
                    end
`ifdef STEP_CHECK_EN
                    ERR:     state <= ERR;
`endif
                    default: state <= PRIME;
                endcase
            end
        end
    end

endmodule
